// File: rtl/video_timing_pkg.sv
// Shared constants and types for the Aliens raster timing generator:
// default video mode, count width and output delay values.
package video_timing_pkg;

    localparam int CNT_W = 9;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int DEF_H_TOTAL      = 384;
    localparam int DEF_H_ACTIVE     = 288;
    localparam int DEF_H_SYNC_START = 312;
    localparam int DEF_H_SYNC_LEN   = 32;
    localparam int DEF_V_TOTAL      = 264;
    localparam int DEF_V_ACTIVE     = 224;
    localparam int DEF_V_SYNC_START = 240;
    localparam int DEF_V_SYNC_LEN   = 8;

    // Board-level output delays in ns, used only by the delayed-output build.
    localparam int DELAY_RISE = 14;
    localparam int DELAY_FALL = 10;

    // Compared in int so that a window ending exactly at 512 does not wrap.
    function automatic logic in_window(cnt_t v, int lo, int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/timing_counter.sv
// Mod-N counter with enable and terminal-count flag; count_next is the value
// the counter takes on the next enabled edge, so callers can decode ahead.
module timing_counter
    import video_timing_pkg::*;
#(
    parameter int N = 2
)(
    input  logic             Clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             tc
);

    assign tc         = (count == CNT_W'(N - 1));
    assign count_next = tc ? '0 : count + CNT_W'(1);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: cascaded pixel/line counters, registered sync and
// blank levels, line/frame strobes and vblank IRQ. Define TIMING_DELAY_EN for delayed outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
)(
    input  logic             Clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             irq_en,
    input  logic             irq_ack,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             line_start,
    output logic             frame_start,
    output logic             irq_n
);

    cnt_t h_cnt;
    cnt_t h_nxt;
    cnt_t v_cnt;
    cnt_t v_nxt;
    cnt_t v_after;
    logic h_tc;
    logic v_tc;
    logic line_wrap;
    logic irq_set;

    logic hblank_r;
    logic vblank_r;
    logic hsync_n_r;
    logic vsync_n_r;
    logic line_start_r;
    logic frame_start_r;
    logic irq_pend;

    assign line_wrap = ce_pix & h_tc;

    timing_counter #(.N(H_TOTAL)) u_hcnt (
        .Clk        (Clk),
        .reset      (reset),
        .en         (ce_pix),
        .count      (h_cnt),
        .count_next (h_nxt),
        .tc         (h_tc)
    );

    timing_counter #(.N(V_TOTAL)) u_vcnt (
        .Clk        (Clk),
        .reset      (reset),
        .en         (line_wrap),
        .count      (v_cnt),
        .count_next (v_nxt),
        .tc         (v_tc)
    );

    // Decode the count as it will be after this edge, so levels and counts
    // change together with no pipeline lag.
    assign v_after = line_wrap ? v_nxt : v_cnt;
    assign irq_set = irq_en & line_wrap & (v_nxt == CNT_W'(V_ACTIVE));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            hblank_r      <= 1'b0;
            vblank_r      <= 1'b0;
            hsync_n_r     <= 1'b1;
            vsync_n_r     <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            line_start_r  <= line_wrap;
            frame_start_r <= line_wrap & v_tc;
            if (ce_pix) begin
                hblank_r  <= (int'(h_nxt) >= H_ACTIVE);
                vblank_r  <= (int'(v_after) >= V_ACTIVE);
                hsync_n_r <= !in_window(h_nxt, H_SYNC_START, H_SYNC_LEN);
                vsync_n_r <= !in_window(v_after, V_SYNC_START, V_SYNC_LEN);
            end
        end
    end

    // A new set outranks a same-edge acknowledge; disabling drops any pending request.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            irq_pend <= 1'b0;
        end else if (!irq_en) begin
            irq_pend <= 1'b0;
        end else if (irq_set) begin
            irq_pend <= 1'b1;
        end else if (irq_ack) begin
            irq_pend <= 1'b0;
        end
    end

`ifdef TIMING_DELAY_EN
    assign #(DELAY_RISE, DELAY_FALL) hcount      = h_cnt;
    assign #(DELAY_RISE, DELAY_FALL) vcount      = v_cnt;
    assign #(DELAY_RISE, DELAY_FALL) hblank      = hblank_r;
    assign #(DELAY_RISE, DELAY_FALL) vblank      = vblank_r;
    assign #(DELAY_RISE, DELAY_FALL) hsync_n     = hsync_n_r;
    assign #(DELAY_RISE, DELAY_FALL) vsync_n     = vsync_n_r;
    assign #(DELAY_RISE, DELAY_FALL) line_start  = line_start_r;
    assign #(DELAY_RISE, DELAY_FALL) frame_start = frame_start_r;
    assign #(DELAY_RISE, DELAY_FALL) irq_n       = !irq_pend;
`else
    assign hcount      = h_cnt;
    assign vcount      = v_cnt;
    assign hblank      = hblank_r;
    assign vblank      = vblank_r;
    assign hsync_n     = hsync_n_r;
    assign vsync_n     = vsync_n_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign irq_n       = !irq_pend;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: a reduced-height instance for frame and
// IRQ scenarios, plus a default-mode instance sharing the same stimulus.
module tb_video_timing_gen;

    // Reduced mode: default horizontal timing, 40-line frame (15360 pixels).
    localparam int VT = 40;
    localparam int VA = 24;
    localparam int VSS = 30;
    localparam int VSL = 4;

    logic Clk = 1'b0;
    logic reset;
    logic ce_pix;
    logic irq_en;
    logic irq_ack;

    logic [8:0] hcount, vcount;
    logic hblank, vblank, hsync_n, vsync_n, line_start, frame_start, irq_n;
    logic [8:0] d_hcount, d_vcount;
    logic d_hblank, d_vblank, d_hsync_n, d_vsync_n, d_line_start, d_frame_start, d_irq_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    video_timing_gen #(
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .Clk(Clk), .reset(reset), .ce_pix(ce_pix), .irq_en(irq_en), .irq_ack(irq_ack),
        .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .line_start(line_start),
        .frame_start(frame_start), .irq_n(irq_n)
    );

    video_timing_gen dut_def (
        .Clk(Clk), .reset(reset), .ce_pix(ce_pix), .irq_en(irq_en), .irq_ack(irq_ack),
        .hcount(d_hcount), .vcount(d_vcount), .hblank(d_hblank), .vblank(d_vblank),
        .hsync_n(d_hsync_n), .vsync_n(d_vsync_n), .line_start(d_line_start),
        .frame_start(d_frame_start), .irq_n(d_irq_n)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        int strobes;
        reset = 1'b0; ce_pix = 1'b1; irq_en = 1'b0; irq_ack = 1'b0;
        repeat (3) step();
        n_cmp++; if (hcount !== 9'd0) begin n_err++; $display("FAIL reset_hcount got %0d exp 0", hcount); end
        n_cmp++; if (vcount !== 9'd0) begin n_err++; $display("FAIL reset_vcount got %0d exp 0", vcount); end
        n_cmp++; if (hblank !== 1'b0) begin n_err++; $display("FAIL reset_hblank got %b exp 0", hblank); end
        n_cmp++; if (vblank !== 1'b0) begin n_err++; $display("FAIL reset_vblank got %b exp 0", vblank); end
        n_cmp++; if (hsync_n !== 1'b1) begin n_err++; $display("FAIL reset_hsync_n got %b exp 1", hsync_n); end
        n_cmp++; if (vsync_n !== 1'b1) begin n_err++; $display("FAIL reset_vsync_n got %b exp 1", vsync_n); end
        n_cmp++; if (line_start !== 1'b0) begin n_err++; $display("FAIL reset_line_start got %b exp 0", line_start); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
        n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL reset_irq_n got %b exp 1", irq_n); end
        n_cmp++; if (d_hcount !== 9'd0) begin n_err++; $display("FAIL reset_def_hcount got %0d exp 0", d_hcount); end
        n_cmp++; if (d_hsync_n !== 1'b1) begin n_err++; $display("FAIL reset_def_hsync_n got %b exp 1", d_hsync_n); end
        reset = 1'b1;
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (line_start || frame_start) strobes++;
        end
        n_cmp++; if (hcount !== 9'd5) begin n_err++; $display("FAIL release_hcount got %0d exp 5", hcount); end
        n_cmp++; if (vcount !== 9'd0) begin n_err++; $display("FAIL release_vcount got %0d exp 0", vcount); end
        n_cmp++; if (d_hcount !== 9'd5) begin n_err++; $display("FAIL release_def_hcount got %0d exp 5", d_hcount); end
        n_cmp++; if (strobes !== 0) begin n_err++; $display("FAIL release_strobes got %0d exp 0", strobes); end
    endtask

    // 384 enabled edges from hcount=5: one full line, crossing the wrap.
    task automatic test_line();
        int hb_rise, hs_first, hs_last, hs_cnt, ls_cnt, ls_v, ls_hb;
        int d_hb_rise, d_hs_first, d_hs_last;
        logic prev_hb, prev_dhb;
        hb_rise = -1; hs_first = -1; hs_last = -1; hs_cnt = 0; ls_cnt = 0; ls_v = -1; ls_hb = -1;
        d_hb_rise = -1; d_hs_first = -1; d_hs_last = -1;
        prev_hb = hblank; prev_dhb = d_hblank;
        for (int i = 0; i < 384; i++) begin
            step();
            if (hblank && !prev_hb) hb_rise = int'(hcount);
            if (d_hblank && !prev_dhb) d_hb_rise = int'(d_hcount);
            prev_hb = hblank; prev_dhb = d_hblank;
            if (!hsync_n) begin
                if (hs_first < 0) hs_first = int'(hcount);
                hs_last = int'(hcount);
                hs_cnt++;
            end
            if (!d_hsync_n) begin
                if (d_hs_first < 0) d_hs_first = int'(d_hcount);
                d_hs_last = int'(d_hcount);
            end
            if (line_start) begin
                ls_cnt++;
                ls_v = (hcount == 9'd0) ? int'(vcount) : -2;
                ls_hb = int'(hblank);
            end
        end
        n_cmp++; if (hb_rise !== 288) begin n_err++; $display("FAIL line_hblank_rise got %0d exp 288", hb_rise); end
        n_cmp++; if (hs_first !== 312) begin n_err++; $display("FAIL line_hsync_first got %0d exp 312", hs_first); end
        n_cmp++; if (hs_last !== 343) begin n_err++; $display("FAIL line_hsync_last got %0d exp 343", hs_last); end
        n_cmp++; if (hs_cnt !== 32) begin n_err++; $display("FAIL line_hsync_width got %0d exp 32", hs_cnt); end
        n_cmp++; if (ls_cnt !== 1) begin n_err++; $display("FAIL line_start_count got %0d exp 1", ls_cnt); end
        n_cmp++; if (ls_v !== 1) begin n_err++; $display("FAIL line_start_at_h0_v1 got %0d exp 1", ls_v); end
        n_cmp++; if (ls_hb !== 0) begin n_err++; $display("FAIL line_hblank_at_h0 got %0d exp 0", ls_hb); end
        n_cmp++; if (hcount !== 9'd5) begin n_err++; $display("FAIL line_end_hcount got %0d exp 5", hcount); end
        n_cmp++; if (vcount !== 9'd1) begin n_err++; $display("FAIL line_end_vcount got %0d exp 1", vcount); end
        n_cmp++; if (d_hb_rise !== 288) begin n_err++; $display("FAIL line_def_hblank_rise got %0d exp 288", d_hb_rise); end
        n_cmp++; if (d_hs_first !== 312) begin n_err++; $display("FAIL line_def_hsync_first got %0d exp 312", d_hs_first); end
        n_cmp++; if (d_hs_last !== 343) begin n_err++; $display("FAIL line_def_hsync_last got %0d exp 343", d_hs_last); end
        n_cmp++; if (d_vcount !== 9'd1) begin n_err++; $display("FAIL line_def_vcount got %0d exp 1", d_vcount); end
    endtask

    task automatic test_frame();
        int cyc, vb_rise_v, vb_rise_h, vs_first, vs_last;
        logic prev_vb;
        cyc = 0;
        while (!frame_start && cyc < 20000) begin
            step();
            cyc++;
        end
        // From (h=5, v=1) to the frame wrap: 15360 - 389 enabled edges.
        n_cmp++; if (cyc !== 14971) begin n_err++; $display("FAIL frame_first_strobe_edges got %0d exp 14971", cyc); end
        n_cmp++; if ({hcount, vcount} !== 18'd0) begin n_err++; $display("FAIL frame_strobe_pos got h=%0d v=%0d exp 0,0", hcount, vcount); end
        cyc = 0; vb_rise_v = -1; vb_rise_h = -1; vs_first = -1; vs_last = -1;
        prev_vb = vblank;
        do begin
            step();
            cyc++;
            if (vblank && !prev_vb) begin
                vb_rise_v = int'(vcount);
                vb_rise_h = int'(hcount);
            end
            prev_vb = vblank;
            if (!vsync_n) begin
                if (vs_first < 0) vs_first = int'(vcount);
                vs_last = int'(vcount);
            end
        end while (!frame_start && cyc < 20000);
        n_cmp++; if (cyc !== 15360) begin n_err++; $display("FAIL frame_period got %0d exp 15360", cyc); end
        n_cmp++; if (vb_rise_v !== VA) begin n_err++; $display("FAIL frame_vblank_rise_line got %0d exp %0d", vb_rise_v, VA); end
        n_cmp++; if (vb_rise_h !== 0) begin n_err++; $display("FAIL frame_vblank_rise_pixel got %0d exp 0", vb_rise_h); end
        n_cmp++; if (vs_first !== VSS) begin n_err++; $display("FAIL frame_vsync_first got %0d exp %0d", vs_first, VSS); end
        n_cmp++; if (vs_last !== VSS + VSL - 1) begin n_err++; $display("FAIL frame_vsync_last got %0d exp %0d", vs_last, VSS + VSL - 1); end
        n_cmp++; if (vblank !== 1'b0) begin n_err++; $display("FAIL frame_vblank_at_wrap got %b exp 0", vblank); end
    endtask

    // Default instance sits at line 80 here; reset it at (200, 100).
    task automatic test_reset_mid();
        int cyc, strobes;
        cyc = 0;
        while (!(d_vcount == 9'd100 && d_hcount == 9'd200) && cyc < 10000) begin
            step();
            cyc++;
        end
        n_cmp++; if (cyc !== 7880) begin n_err++; $display("FAIL mid_reach_edges got %0d exp 7880", cyc); end
        n_cmp++; if ({hcount, vcount} !== {9'd200, 9'd20}) begin n_err++; $display("FAIL mid_scaled_pos got h=%0d v=%0d exp 200,20", hcount, vcount); end
        reset = 1'b0;
        #2;
        n_cmp++; if ({d_hcount, d_vcount} !== 18'd0) begin n_err++; $display("FAIL mid_def_async_clear got h=%0d v=%0d exp 0,0", d_hcount, d_vcount); end
        n_cmp++; if ({hcount, vcount} !== 18'd0) begin n_err++; $display("FAIL mid_async_clear got h=%0d v=%0d exp 0,0", hcount, vcount); end
        n_cmp++; if ({d_hsync_n, d_vsync_n, d_irq_n} !== 3'b111) begin n_err++; $display("FAIL mid_def_levels got %b exp 111", {d_hsync_n, d_vsync_n, d_irq_n}); end
        repeat (2) step();
        reset = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (line_start || frame_start || d_line_start || d_frame_start) strobes++;
        end
        n_cmp++; if (strobes !== 0) begin n_err++; $display("FAIL mid_no_strobes got %0d exp 0", strobes); end
        n_cmp++; if ({d_hcount, d_vcount} !== {9'd3, 9'd0}) begin n_err++; $display("FAIL mid_def_resume got h=%0d v=%0d exp 3,0", d_hcount, d_vcount); end
        n_cmp++; if ({hcount, vcount} !== {9'd3, 9'd0}) begin n_err++; $display("FAIL mid_resume got h=%0d v=%0d exp 3,0", hcount, vcount); end
    endtask

    task automatic test_irq();
        int cyc;
        irq_en = 1'b1;
        cyc = 0;
        while (!(hcount == 9'd383 && vcount == 9'(VA - 1)) && cyc < 20000) begin
            step();
            cyc++;
        end
        n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL irq_before_set got %b exp 1", irq_n); end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_cmp++; if ({hcount, vcount} !== {9'd0, 9'(VA)}) begin n_err++; $display("FAIL irq_set_pos got h=%0d v=%0d exp 0,%0d", hcount, vcount, VA); end
        n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL irq_set_wins got %b exp 0", irq_n); end
        repeat (10) step();
        n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL irq_level_held got %b exp 0", irq_n); end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL irq_ack_clear got %b exp 1", irq_n); end
        repeat (5) step();
        n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL irq_no_reassert got %b exp 1", irq_n); end
    endtask

    // One enable per four clocks across a line wrap: 381 -> 382, 383, 0, 1.
    task automatic test_ce_quarter();
        int cyc, ls_cnt, ls_at, h_hold;
        cyc = 0;
        while (hcount != 9'd381 && cyc < 1000) begin
            step();
            cyc++;
        end
        ls_cnt = 0; ls_at = -1; h_hold = -1;
        for (int i = 0; i < 16; i++) begin
            ce_pix = (i % 4 == 0);
            step();
            if (line_start) begin
                ls_cnt++;
                ls_at = i;
            end
            if (i == 3) h_hold = int'(hcount);
        end
        ce_pix = 1'b1;
        n_cmp++; if (h_hold !== 382) begin n_err++; $display("FAIL ce_hold_hcount got %0d exp 382", h_hold); end
        n_cmp++; if (ls_cnt !== 1) begin n_err++; $display("FAIL ce_line_start_width got %0d exp 1", ls_cnt); end
        n_cmp++; if (ls_at !== 8) begin n_err++; $display("FAIL ce_line_start_clock got %0d exp 8", ls_at); end
        n_cmp++; if ({hcount, vcount} !== {9'd1, 9'(VA + 1)}) begin n_err++; $display("FAIL ce_end_pos got h=%0d v=%0d exp 1,%0d", hcount, vcount, VA + 1); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_reset_mid();
        test_irq();
        test_ce_quarter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the Aliens video path: cascaded horizontal and vertical pixel counters producing sync, blank, line/frame strobes and the vblank CPU interrupt. It sits directly upstream of the flip-flop stages in the video pipeline and drives their clock-enable and data inputs. Outputs are registered so downstream flip-flops see glitch-free levels. Optional gate-delay modelling matches the board-level timing style of the rest of the design.

## Interface
- H_TOTAL, 384, pixels per line; 2..512.
- H_ACTIVE, 288, visible pixels per line; less than H_TOTAL.
- H_SYNC_START, 312, first hcount with hsync_n low.
- H_SYNC_LEN, 32, hsync width in pixels; H_SYNC_START+H_SYNC_LEN ≤ H_TOTAL.
- V_TOTAL, 264, lines per frame; 2..512.
- V_ACTIVE, 224, visible lines per frame; less than V_TOTAL.
- V_SYNC_START, 240, first vcount with vsync_n low.
- V_SYNC_LEN, 8, vsync width in lines; V_SYNC_START+V_SYNC_LEN ≤ V_TOTAL.
- DELAY_RISE, 14, output rise delay in ns (macro only).
- DELAY_FALL, 10, output fall delay in ns (macro only).
- Clk  in  1  master clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce_pix  in  1  pixel clock enable; counters advance only on edges where it is 1.
- irq_en  in  1  vblank interrupt enable.
- irq_ack  in  1  interrupt acknowledge, sampled on Clk.
- hcount  out  9  current pixel, 0..H_TOTAL-1.
- vcount  out  9  current line, 0..V_TOTAL-1.
- hblank  out  1  high when hcount ≥ H_ACTIVE.
- vblank  out  1  high when vcount ≥ V_ACTIVE.
- hsync_n  out  1  low when H_SYNC_START ≤ hcount < H_SYNC_START+H_SYNC_LEN.
- vsync_n  out  1  low when V_SYNC_START ≤ vcount < V_SYNC_START+V_SYNC_LEN.
- line_start  out  1  one-Clk pulse after hcount wraps to 0.
- frame_start  out  1  one-Clk pulse after hcount and vcount both wrap to 0.
- irq_n  out  1  vblank interrupt, active-low, level-held until acknowledged.

## Operation
- Reset (reset low, asynchronous): hcount=0, vcount=0, hblank=0, vblank=0, hsync_n=1, vsync_n=1, line_start=0, frame_start=0, irq_n=1.
- Reset released mid-frame: counting restarts from 0,0. No line_start or frame_start is emitted for the reset state itself.
- On a Clk edge with ce_pix=1, hcount increments.
  - At H_TOTAL-1 it wraps to 0, and vcount increments on the same edge.
  - vcount wraps to 0 from V_TOTAL-1.
- On a Clk edge with ce_pix=0, all counters and decoded levels hold. line_start and frame_start return to 0.
- hblank, vblank, hsync_n and vsync_n are registered. They are updated on the same edge as the counters and always decode the new count values.
- Interrupt pending flag:
  - Set on the edge where vcount becomes V_ACTIVE (and hcount becomes 0) while irq_en=1.
  - Cleared on an edge with irq_ack=1.
  - Set and ack on the same edge: set wins.
  - irq_en=0 forces the flag clear.
  - irq_n is the inverse of the flag.

## Timing
- Latency from count to decoded outputs: 0. Decoded outputs change on the same edge as the count.
- line_start and frame_start are high exactly one Clk cycle, starting on the edge that produces hcount=0.
- irq_n falls on the edge that produces vcount=V_ACTIVE, hcount=0. It rises on the first edge with irq_ack=1, or irq_en=0, and no new set.
- Frame period = H_TOTAL×V_TOTAL ce_pix pulses; 101376 with the defaults.

## Configuration
- TIMING_DELAY_EN defined: every output is driven through continuous assigns with #(DELAY_RISE, DELAY_FALL). The module is for gate-level-style board simulation only.
- TIMING_DELAY_EN undefined: outputs are driven with zero delay. This build is synthesizable; DELAY_RISE and DELAY_FALL are ignored.

## Structure
- Shared package video_timing_pkg holds:
  - the default Aliens mode constants (the H_*/V_* values above);
  - CNT_W=9;
  - a typedef for the 9-bit count.
- One sub-module, timing_counter: mod-N counter with enable, async active-low reset and a terminal-count output. It is instantiated twice, horizontal and vertical, with the horizontal terminal count gating the vertical enable.

## Test plan
- Reset held low, ce_pix=1 -> all outputs at their reset values. After release, hcount reaches 5 after 5 enabled edges.
- ce_pix=1 continuous for 384 edges -> hcount wraps 383->0, vcount 0->1, line_start high for exactly 1 cycle. hblank rises at hcount=288. hsync_n is low for hcount 312..343.
- Run a full frame -> vblank rises at vcount=224, vsync_n low for lines 240..247. frame_start pulses once at 101376 enabled edges.
- irq_en=1, irq_ack asserted on the same edge vcount becomes 224 -> irq_n goes low (set wins). A later irq_ack returns irq_n to 1.
- ce_pix toggling 1-of-4 -> counters advance once per 4 Clk. line_start stays 1 Clk wide.
- reset pulsed low at vcount=100, hcount=200 -> outputs clear immediately. Counting resumes from 0,0 with no spurious strobes.
